// File: rtl/tx_frame_pkg.sv
// Shared types, frame constants and parity helper for the transmit framing controller.
package tx_frame_pkg;

   // Controller states; encoding is binary.
   typedef enum logic [1:0] {
      FLUSH = 2'd0,
      IDLE  = 2'd1,
      LOAD  = 2'd2,
      SEND  = 2'd3
   } state_e;

   localparam logic START_BIT = 1'b0;
   localparam logic STOP_BIT  = 1'b1;

   // Widest payload the parity helper accepts; narrower words are zero-extended,
   // which leaves the XOR reduction unchanged.
   localparam int MAX_DATA_BITS = 64;

   // Even parity is the XOR of all data bits; odd parity is its inverse.
   function automatic logic calc_parity(input logic [MAX_DATA_BITS-1:0] data,
                                        input logic                     odd);
      return (^data) ^ odd;
   endfunction

endpackage

// File: rtl/tx_frame_ctrl_baud_timer.sv
// Bit-period timer: counts 0..TC_VALUE while enabled, wraps at terminal count.
import tx_frame_pkg::*;

module baud_timer #(
   parameter int TC_VALUE = 9,
   parameter int CNT_W    = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic en_i,
   input  logic clr_i,
   output logic tc_o
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic             at_tc;

   assign at_tc = (cnt_q == CNT_W'(TC_VALUE));
   assign tc_o  = en_i && at_tc;

   // Next count: clear has priority, then wrap on terminal count, else increment.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         if (at_tc) begin
            cnt_d = '0;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   // Count register with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/tx_frame_ctrl.sv
// Transmit framing controller driving an LSB-first, idle-high-fill parallel-to-serial
// shift register: builds start/data/parity/stop frames and paces the shift strobes.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   FLUSH | load all ones into the shift register so the line rests high
//   IDLE  | tx_ready high, waiting for a word
//   LOAD  | present frame image and pulse pts_load
//   SEND  | pulse pts_shift once per bit period until the frame is out
import tx_frame_pkg::*;

module tx_frame_ctrl #(
   parameter  int DATA_BITS    = 8,
   parameter  int CLKS_PER_BIT = 10,
   parameter  int PARITY_EN    = 1,
   parameter  int PARITY_ODD   = 0,
   localparam int FRAME_BITS   = DATA_BITS + 2 + PARITY_EN
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_BITS-1:0]  tx_data,
   input  logic                  tx_valid,
   output logic                  tx_ready,
   output logic [FRAME_BITS-1:0] pts_data,
   output logic                  pts_load,
   output logic                  pts_shift,
   output logic                  tx_busy,
   output logic                  frame_done
);

   localparam int TMR_W  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int BCNT_W = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
   localparam logic [BCNT_W-1:0] LAST_BIT = BCNT_W'(FRAME_BITS - 1);

   state_e                state_q, state_d;
   logic [DATA_BITS-1:0]  data_q, data_d;
   logic [BCNT_W-1:0]     bcnt_q, bcnt_d;
   logic [FRAME_BITS-1:0] frame_img;
   logic                  parity_bit;
   logic                  bit_tc;
   logic                  tmr_en;
   logic                  tmr_clr;

   assign tmr_en  = (state_q == SEND);
   assign tmr_clr = (state_q == LOAD);

   baud_timer #(
      .TC_VALUE (CLKS_PER_BIT - 1),
      .CNT_W    (TMR_W)
   ) u_baud_timer (
      .clk   (clk),
      .rst   (rst),
      .en_i  (tmr_en),
      .clr_i (tmr_clr),
      .tc_o  (bit_tc)
   );

   assign parity_bit = calc_parity(MAX_DATA_BITS'(data_q), (PARITY_ODD != 0));

   // Frame image: start bit at LSB, data LSB-first, optional parity, stop bit at MSB.
   always_comb begin
      frame_img                = '1;
      frame_img[0]             = START_BIT;
      frame_img[DATA_BITS:1]   = data_q;
      if (PARITY_EN != 0) begin
         frame_img[DATA_BITS+1] = parity_bit;
      end
      frame_img[FRAME_BITS-1]  = STOP_BIT;
   end

   // Next-state, datapath updates and strobes.
   always_comb begin
      state_d    = state_q;
      data_d     = data_q;
      bcnt_d     = bcnt_q;
      tx_ready   = 1'b0;
      pts_load   = 1'b0;
      pts_shift  = 1'b0;
      tx_busy    = 1'b0;
      frame_done = 1'b0;
      pts_data   = frame_img;

      case (state_q)
         FLUSH: begin
            pts_load = 1'b1;
            pts_data = '1;
            state_d  = IDLE;
         end
         IDLE: begin
            tx_ready = 1'b1;
            if (tx_valid) begin
               data_d  = tx_data;
               state_d = LOAD;
            end
         end
         LOAD: begin
            pts_load = 1'b1;
            tx_busy  = 1'b1;
            bcnt_d   = '0;
            state_d  = SEND;
         end
         SEND: begin
            tx_busy = 1'b1;
            if (bit_tc) begin
               pts_shift = 1'b1;
               if (bcnt_q == LAST_BIT) begin
                  frame_done = 1'b1;
                  state_d    = IDLE;
               end else begin
                  bcnt_d = bcnt_q + 1'b1;
               end
            end
         end
         default: begin
            state_d = FLUSH;
         end
      endcase
   end

   // State and datapath registers; reset abandons any frame and restarts with a flush.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= FLUSH;
         data_q  <= '0;
         bcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         bcnt_q  <= bcnt_d;
      end
   end

endmodule

// File: tb/tb_tx_frame_ctrl.sv
// Directed bench for tx_frame_ctrl with a behavioural LSB-first, ones-fill shift register.
module tb_tx_frame_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] tx_data = 8'h00;
   logic       tx_valid = 1'b0;

   always #5 clk = ~clk;

   // instance 0: even parity, 4 clks/bit; 1: odd parity; 2: no parity; 3: 1 clk/bit
   logic        rdy0, rdy1, rdy2, rdy3;
   logic        bsy0, bsy1, bsy2, bsy3;
   logic        ld0, ld1, ld2, ld3;
   logic        sh0, sh1, sh2, sh3;
   logic        dn0, dn1, dn2, dn3;
   logic [10:0] pd0, pd1, pd3;
   logic [9:0]  pd2;

   tx_frame_ctrl #(.DATA_BITS(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(0)) dut (
      .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(rdy0),
      .pts_data(pd0), .pts_load(ld0), .pts_shift(sh0), .tx_busy(bsy0), .frame_done(dn0));

   tx_frame_ctrl #(.DATA_BITS(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(1)) dut_odd (
      .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(rdy1),
      .pts_data(pd1), .pts_load(ld1), .pts_shift(sh1), .tx_busy(bsy1), .frame_done(dn1));

   tx_frame_ctrl #(.DATA_BITS(8), .CLKS_PER_BIT(4), .PARITY_EN(0), .PARITY_ODD(0)) dut_np (
      .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(rdy2),
      .pts_data(pd2), .pts_load(ld2), .pts_shift(sh2), .tx_busy(bsy2), .frame_done(dn2));

   tx_frame_ctrl #(.DATA_BITS(8), .CLKS_PER_BIT(1), .PARITY_EN(1), .PARITY_ODD(0)) dut_c1 (
      .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(rdy3),
      .pts_data(pd3), .pts_load(ld3), .pts_shift(sh3), .tx_busy(bsy3), .frame_done(dn3));

   // downstream shift registers: load has priority, shift moves right with ones fill
   logic [10:0] sr0 = '0, sr1 = '0, sr3 = '0;
   logic [9:0]  sr2 = '0;

   always @(posedge clk) begin
      if (ld0) sr0 <= pd0; else if (sh0) sr0 <= {1'b1, sr0[10:1]};
      if (ld1) sr1 <= pd1; else if (sh1) sr1 <= {1'b1, sr1[10:1]};
      if (ld2) sr2 <= pd2; else if (sh2) sr2 <= {1'b1, sr2[9:1]};
      if (ld3) sr3 <= pd3; else if (sh3) sr3 <= {1'b1, sr3[10:1]};
   end

   int          cur = 0;
   logic        m_ready, m_busy, m_load, m_shift, m_done, m_ser;
   logic [10:0] m_data;

   always_comb begin
      m_ready = rdy0; m_busy = bsy0; m_load = ld0; m_shift = sh0; m_done = dn0;
      m_ser = sr0[0]; m_data = pd0;
      case (cur)
         1: begin m_ready = rdy1; m_busy = bsy1; m_load = ld1; m_shift = sh1; m_done = dn1;
                  m_ser = sr1[0]; m_data = pd1; end
         2: begin m_ready = rdy2; m_busy = bsy2; m_load = ld2; m_shift = sh2; m_done = dn2;
                  m_ser = sr2[0]; m_data = {1'b0, pd2}; end
         3: begin m_ready = rdy3; m_busy = bsy3; m_load = ld3; m_shift = sh3; m_done = dn3;
                  m_ser = sr3[0]; m_data = pd3; end
         default: ;
      endcase
   end

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp)
         $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, obs, exp, $time);
      else
         n_pass++;
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   // Reset, then check the flush cycle and the first idle cycle.
   task automatic do_reset(input int sel);
      logic [10:0] ones;
      cur      = sel;
      ones     = (sel == 2) ? 11'h3FF : 11'h7FF;
      tx_valid = 1'b0;
      rst      = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      chk("flush_load",  m_load,  1);
      chk("flush_data",  m_data,  ones);
      chk("flush_ready", m_ready, 0);
      chk("flush_shift", m_shift, 0);
      chk("flush_busy",  m_busy,  0);
      chk("flush_done",  m_done,  0);
      tick();
      chk("idle_ready", m_ready, 1);
      chk("idle_ser",   m_ser,   1);
      chk("idle_load",  m_load,  0);
   endtask

   // Called in the handshake cycle T; returns in the IDLE cycle after frame_done.
   task automatic expect_frame(input logic [10:0] fr, input int nbits, input int cpb,
                               input logic [7:0] nxt, input logic keep);
      int n;
      n = nbits * cpb;
      chk("hs_ready", m_ready, 1);
      tick();
      chk("load_strobe", m_load,  1);
      chk("load_data",   m_data,  fr);
      chk("load_busy",   m_busy,  1);
      chk("load_ready",  m_ready, 0);
      chk("load_shift",  m_shift, 0);
      tx_data  = nxt;
      tx_valid = keep;
      for (int k = 0; k < n; k++) begin
         tick();
         chk($sformatf("ser[%0d]", k),   m_ser,   fr[k / cpb]);
         chk($sformatf("shift[%0d]", k), m_shift, ((k % cpb) == (cpb - 1)));
         chk($sformatf("done[%0d]", k),  m_done,  (k == n - 1));
         chk($sformatf("excl[%0d]", k),  {m_load, m_ready}, 2'b00);
      end
      tick();
      chk("end_ready", m_ready, 1);
      chk("end_busy",  m_busy,  0);
      chk("end_ser",   m_ser,   1);
      chk("end_done",  m_done,  0);
   endtask

   initial begin
      // reset release and even-parity frame of 8'hA5
      do_reset(0);
      tx_data = 8'hA5; tx_valid = 1'b1;
      expect_frame(11'h54A, 11, 4, 8'h00, 1'b0);

      // odd parity, 8'h01
      do_reset(1);
      tx_data = 8'h01; tx_valid = 1'b1;
      expect_frame(11'h402, 11, 4, 8'hFE, 1'b0);

      // no parity, 8'hFF: 10-bit frame
      do_reset(2);
      tx_data = 8'hFF; tx_valid = 1'b1;
      expect_frame(11'h3FE, 10, 4, 8'h00, 1'b0);

      // back-to-back: valid held, data switched to the second word mid-frame
      do_reset(0);
      tx_data = 8'h3C; tx_valid = 1'b1;
      expect_frame(11'h478, 11, 4, 8'hC3, 1'b1);
      expect_frame(11'h586, 11, 4, 8'h00, 1'b0);

      // reset in the middle of data bit 3, then a clean frame
      do_reset(0);
      tx_data = 8'h5A; tx_valid = 1'b1;
      tick();
      chk("mid_load", m_load, 1);
      tx_valid = 1'b0;
      for (int k = 0; k < 18; k++) begin
         tick();
         chk($sformatf("mid_done[%0d]", k), m_done, 0);
      end
      chk("mid_ser_d3", m_ser, 1);
      rst = 1'b1;
      tick();
      chk("rst_flush_load", m_load, 1);
      chk("rst_flush_data", m_data, 11'h7FF);
      chk("rst_flush_done", m_done, 0);
      chk("rst_flush_busy", m_busy, 0);
      rst = 1'b0;
      tick();
      chk("rst_idle_ready", m_ready, 1);
      chk("rst_idle_ser",   m_ser,   1);
      chk("rst_idle_done",  m_done,  0);
      tx_data = 8'hA5; tx_valid = 1'b1;
      expect_frame(11'h54A, 11, 4, 8'h33, 1'b0);

      // one clock per bit: shift every SEND cycle
      do_reset(3);
      tx_data = 8'h5A; tx_valid = 1'b1;
      expect_frame(11'h4B4, 11, 1, 8'h00, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
